// File: rtl/sdr_ctrl_if_gen2_if.sv
// Host-side bundle of the SDR controller command interface.
// Master drives command/address/acks; slave returns decode, config and refresh status.
interface sdr_ctrl_if_gen2_if #(
  parameter int ASIZE = 23,
  parameter int PW    = 4
);
  logic [2:0]       cmd;
  logic [ASIZE-1:0] addr;
  logic             cm_ack;
  logic             ref_ack;
  logic             nop;
  logic             reada;
  logic             writea;
  logic             refresh;
  logic             precharge;
  logic             load_mode;
  logic [ASIZE-1:0] saddr;
  logic [1:0]       sc_cl;
  logic [1:0]       sc_rc;
  logic [3:0]       sc_rrd;
  logic             sc_pm;
  logic [3:0]       sc_bl;
  logic             cfg_done;
  logic             ref_req;
  logic             ref_urgent;
  logic             ref_ovf;
  logic [PW-1:0]    ref_pend;
  logic             cmd_ack;

  modport master (
    output cmd, addr, cm_ack, ref_ack,
    input  nop, reada, writea, refresh, precharge, load_mode, saddr,
    input  sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl, cfg_done,
    input  ref_req, ref_urgent, ref_ovf, ref_pend, cmd_ack
  );

  modport slave (
    input  cmd, addr, cm_ack, ref_ack,
    output nop, reada, writea, refresh, precharge, load_mode, saddr,
    output sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl, cfg_done,
    output ref_req, ref_urgent, ref_ovf, ref_pend, cmd_ack
  );
endinterface

// File: rtl/sdr_ctrl_if_gen2.sv
// Host command interface, gen2: registered decode, timing config,
// refresh timer with a saturating postponed-refresh counter.
module sdr_ctrl_if_gen2 #(
  parameter int ASIZE      = 23,
  parameter int REF_W      = 16,
  parameter int MAX_PEND   = 8,
  parameter int URG_THRESH = 6,
  parameter int PW         = 4
) (
  input logic              clk,
  input logic              rst,
  sdr_ctrl_if_gen2_if.slave bus
);

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_RDA  = 3'd1;
  localparam logic [2:0] C_WRA  = 3'd2;
  localparam logic [2:0] C_REF  = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_LMR  = 3'd5;
  localparam logic [2:0] C_LR1  = 3'd6;
  localparam logic [2:0] C_LR2  = 3'd7;

  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PURG = PW'(URG_THRESH);

  logic             nop, reada, writea, refresh, precharge, load_mode;
  logic [ASIZE-1:0] saddr;
  logic             load_reg1, load_reg2, cmd_ack;
  logic [1:0]       sc_cl, sc_rc;
  logic [3:0]       sc_rrd, sc_bl;
  logic             sc_pm, cfg_done;
  logic [REF_W-1:0] ref_per, timer;
  logic             tmr_en, tick, ack_ok, ovf_set;
  logic [PW-1:0]    pend, pend_nxt;
  logic             ref_req, ref_urgent, ref_ovf;

  // Register the one-hot command decode together with the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nop       <= 1'b0;
      reada     <= 1'b0;
      writea    <= 1'b0;
      refresh   <= 1'b0;
      precharge <= 1'b0;
      load_mode <= 1'b0;
      saddr     <= '0;
    end else begin
      nop       <= (bus.cmd == C_NOP);
      reada     <= (bus.cmd == C_RDA);
      writea    <= (bus.cmd == C_WRA);
      refresh   <= (bus.cmd == C_REF);
      precharge <= (bus.cmd == C_PRE);
      load_mode <= (bus.cmd == C_LMR);
      saddr     <= bus.addr;
    end
  end

  // Single-shot config strobes and the host acknowledge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_reg1 <= 1'b0;
      load_reg2 <= 1'b0;
      cmd_ack   <= 1'b0;
    end else begin
      load_reg1 <= (bus.cmd == C_LR1) & ~load_reg1 & ~cmd_ack;
      load_reg2 <= (bus.cmd == C_LR2) & ~load_reg2 & ~cmd_ack;
      cmd_ack   <= (bus.cm_ack | load_reg1 | load_reg2) & ~cmd_ack;
    end
  end

  // Apply timing/mode and refresh period from the registered payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cl    <= '0;
      sc_rc    <= '0;
      sc_rrd   <= '0;
      sc_pm    <= 1'b0;
      sc_bl    <= '0;
      cfg_done <= 1'b0;
      ref_per  <= '0;
    end else begin
      if (load_reg1) begin
        sc_cl    <= saddr[1:0];
        sc_rc    <= saddr[3:2];
        sc_rrd   <= saddr[7:4];
        sc_pm    <= saddr[8];
        sc_bl    <= saddr[12:9];
        cfg_done <= 1'b1;
      end
      if (load_reg2) begin
        ref_per <= saddr[REF_W-1:0];
      end
    end
  end

  assign tmr_en = (ref_per != '0) & cfg_done;
  assign tick   = tmr_en & (timer == '0);
  assign ack_ok = bus.ref_ack & (pend != '0);

  // Refresh down-counter, reloading on zero; a period write restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (load_reg2) begin
      timer <= saddr[REF_W-1:0];
    end else if (tmr_en) begin
      timer <= (timer == '0) ? ref_per : timer - 1'b1;
    end
  end

  // Next pending count: ticks add, acks remove, collisions cancel
  always_comb begin
    pend_nxt = pend;
    ovf_set  = 1'b0;
    if (tick & ~ack_ok) begin
      if (pend < PMAX) pend_nxt = pend + 1'b1;
      else             ovf_set  = 1'b1;
    end else if (~tick & ack_ok) begin
      pend_nxt = pend - 1'b1;
    end
  end

  // Register pending count with its request/urgent/overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      ref_req    <= 1'b0;
      ref_urgent <= 1'b0;
      ref_ovf    <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      ref_req    <= (pend_nxt != '0);
      ref_urgent <= (pend_nxt >= PURG);
      ref_ovf    <= load_reg2 ? 1'b0 : (ref_ovf | ovf_set);
    end
  end

  assign bus.nop        = nop;
  assign bus.reada      = reada;
  assign bus.writea     = writea;
  assign bus.refresh    = refresh;
  assign bus.precharge  = precharge;
  assign bus.load_mode  = load_mode;
  assign bus.saddr      = saddr;
  assign bus.sc_cl      = sc_cl;
  assign bus.sc_rc      = sc_rc;
  assign bus.sc_rrd     = sc_rrd;
  assign bus.sc_pm      = sc_pm;
  assign bus.sc_bl      = sc_bl;
  assign bus.cfg_done   = cfg_done;
  assign bus.ref_req    = ref_req;
  assign bus.ref_urgent = ref_urgent;
  assign bus.ref_ovf    = ref_ovf;
  assign bus.ref_pend   = pend;
  assign bus.cmd_ack    = cmd_ack;

endmodule

// File: tb/tb_sdr_ctrl_if_gen2.sv
// Bench for sdr_ctrl_if_gen2: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_sdr_ctrl_if_gen2;

  localparam int ASIZE = 23;
  localparam int REF_W = 16;
  localparam int MAXP  = 8;
  localparam int URG   = 6;
  localparam int PW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdr_ctrl_if_gen2_if #(.ASIZE(ASIZE), .PW(PW)) bus ();

  sdr_ctrl_if_gen2 #(
    .ASIZE(ASIZE), .REF_W(REF_W), .MAX_PEND(MAXP),
    .URG_THRESH(URG), .PW(PW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural model state
  logic [5:0]       m_dec;
  logic [ASIZE-1:0] m_sa;
  bit               m_lr1, m_lr2, m_ack;
  int               m_cl, m_rc, m_rrd, m_pm, m_bl;
  bit               m_done, m_ovf;
  int               m_per, m_phase, m_pend;

  task automatic model_clear();
    m_dec = '0; m_sa = '0;
    m_lr1 = 0; m_lr2 = 0; m_ack = 0;
    m_cl = 0; m_rc = 0; m_rrd = 0; m_pm = 0; m_bl = 0;
    m_done = 0; m_ovf = 0;
    m_per = 0; m_phase = 0; m_pend = 0;
  endtask

  // a tick lands every (per+1) enabled cycles, the first after per cycles
  function automatic bit model_tick();
    return (m_per != 0) && m_done && ((m_phase % (m_per + 1)) == m_per);
  endfunction

  task automatic model_step(input logic [2:0] c, input logic [ASIZE-1:0] a,
                            input bit cma, input bit rfa);
    bit tk, ak, en, o_lr1, o_lr2, o_ack, novf;
    int np;
    logic [ASIZE-1:0] o_sa;
    logic [5:0] d;
    tk = model_tick();
    ak = rfa && (m_pend != 0);
    en = (m_per != 0) && m_done;
    o_lr1 = m_lr1; o_lr2 = m_lr2; o_ack = m_ack; o_sa = m_sa;
    np = m_pend; novf = m_ovf;
    if (tk && !ak) begin
      if (m_pend < MAXP) np++;
      else novf = 1;
    end else if (!tk && ak) begin
      np--;
    end
    if (en) m_phase++;
    if (o_lr1) begin
      m_cl = int'(o_sa[1:0]); m_rc = int'(o_sa[3:2]);
      m_rrd = int'(o_sa[7:4]); m_pm = int'(o_sa[8]);
      m_bl = int'(o_sa[12:9]); m_done = 1;
    end
    if (o_lr2) begin
      m_per = int'(o_sa[REF_W-1:0]); m_phase = 0; novf = 0;
    end
    m_pend = np; m_ovf = novf;
    m_ack = (cma || o_lr1 || o_lr2) && !o_ack;
    m_lr1 = (c == 3'd6) && !o_lr1 && !o_ack;
    m_lr2 = (c == 3'd7) && !o_lr2 && !o_ack;
    d = '0;
    if (c < 3'd6) d[c] = 1'b1;
    m_dec = d;
    m_sa = a;
  endtask

  task automatic compare_all();
    chk("dec", {bus.load_mode, bus.precharge, bus.refresh,
                bus.writea, bus.reada, bus.nop}, m_dec);
    chk("saddr", bus.saddr, m_sa);
    chk("sc_cl", bus.sc_cl, m_cl);
    chk("sc_rc", bus.sc_rc, m_rc);
    chk("sc_rrd", bus.sc_rrd, m_rrd);
    chk("sc_pm", bus.sc_pm, m_pm);
    chk("sc_bl", bus.sc_bl, m_bl);
    chk("cfg_done", bus.cfg_done, m_done);
    chk("ref_pend", bus.ref_pend, m_pend);
    chk("ref_req", bus.ref_req, m_pend != 0);
    chk("ref_urgent", bus.ref_urgent, m_pend >= URG);
    chk("ref_ovf", bus.ref_ovf, m_ovf);
    chk("cmd_ack", bus.cmd_ack, m_ack);
  endtask

  task automatic step(input logic [2:0] c, input logic [ASIZE-1:0] a,
                      input bit cma, input bit rfa);
    bus.cmd = c; bus.addr = a; bus.cm_ack = cma; bus.ref_ack = rfa;
    @(posedge clk);
    if (rst) model_clear();
    else model_step(c, a, cma, rfa);
    #1 compare_all();
  endtask

  task automatic nop_step();
    step(3'd0, '0, 0, 0);
  endtask

  // hold a config command until acknowledged, then return to NOP
  task automatic host_cmd(input logic [2:0] c, input logic [ASIZE-1:0] a);
    int k = 0;
    do begin
      step(c, a, 0, 0);
      k++;
    end while (!bus.cmd_ack && k < 8);
    chk("ack_seen", bus.cmd_ack, 1);
    nop_step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_async_pend", bus.ref_pend, 0);
    chk("rst_async_done", bus.cfg_done, 0);
    nop_step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [ASIZE-1:0] a;
    logic [2:0] c;
    int r;
    bus.cmd = 3'd1; bus.addr = '0; bus.cm_ack = 0; bus.ref_ack = 0;
    model_clear();
    @(posedge clk);
    #1;

    // reset held with READA on the bus
    repeat (3) step(3'd1, 23'h55, 0, 0);
    rst = 1'b0;
    step(3'd1, 23'h55, 0, 0);
    chk("t1_reada", bus.reada, 1);

    // decode sweep
    for (int i = 0; i < 6; i++) begin
      step(3'(i), 23'(32'h1234 + i), 0, 0);
      chk("t2_saddr", bus.saddr, 32'h1234 + i);
    end

    // timing config
    host_cmd(3'd6, 23'h0F5A);
    chk("t3_cl", bus.sc_cl, 2);
    chk("t3_rc", bus.sc_rc, 2);
    chk("t3_rrd", bus.sc_rrd, 5);
    chk("t3_pm", bus.sc_pm, 1);
    chk("t3_bl", bus.sc_bl, 7);
    chk("t3_done", bus.cfg_done, 1);

    // refresh period 9: saturate and overflow
    host_cmd(3'd7, 23'd9);
    repeat (100) nop_step();
    chk("t4_sat", bus.ref_pend, MAXP);
    chk("t4_ovf", bus.ref_ovf, 1);
    chk("t4_urg", bus.ref_urgent, 1);

    // tick/ack collision, then ack with nothing pending
    pulse_reset();
    host_cmd(3'd6, 23'h0F5A);
    host_cmd(3'd7, 23'd9);
    k = 0;
    while (!(m_pend == 3 && model_tick()) && k < 200) begin
      nop_step(); k++;
    end
    step(3'd0, '0, 0, 1);
    chk("t5_collide", bus.ref_pend, 3);
    k = 0;
    while (m_pend != 0 && k < 50) begin
      step(3'd0, '0, 0, !model_tick()); k++;
    end
    k = 0;
    while (model_tick() && k < 5) begin
      nop_step(); k++;
    end
    step(3'd0, '0, 0, 1);
    chk("t5_zero", bus.ref_pend, 0);

    // mid-run reset
    k = 0;
    while (!(m_pend == 5 && (m_phase % 10) == 4) && k < 300) begin
      nop_step(); k++;
    end
    chk("t6_pre", bus.ref_pend, 5);
    pulse_reset();
    chk("t6_req", bus.ref_req, 0);
    repeat (30) nop_step();
    chk("t6_idle", bus.ref_pend, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      r = $urandom_range(0, 99);
      if (r < 70) c = 3'($urandom_range(0, 5));
      else if (r < 85) c = 3'd6;
      else c = 3'd7;
      a = 23'($urandom);
      if ($urandom_range(0, 9) < 7) a[15:0] = 16'($urandom_range(0, 30));
      else a[15:13] = 3'b000;
      step(c, a, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
